ifid_stall_flush_ctrl: RTL

//  Consumes the load-use stall and branch flush requests. Owns the PC and IF/ID registers.
//  - pc_write / ifid_write gate PC and IF/ID updates.
//  - ctrl_sel=0 zeroes ID/EX control, i.e. inserts a bubble.
//  - Adds a memory-wait freeze, a deferred flush captured during the freeze, and a stall watchdog.
//  - Sits between the IF stage and the ID stage.

---
 rtl/ifid_stall_flush_ctrl_if.sv | 31 +++
 rtl/ifid_stall_flush_ctrl.sv | 125 ++++++++++++
 2 files changed

// File: rtl/ifid_stall_flush_ctrl_if.sv
// Bundles the front-end control signals between the IF/ID stall/flush controller and its neighbours.
// The slave modport is the controller's view; the master modport drives it.
interface ifid_stall_flush_ctrl_if;
    logic        stall;
    logic        mem_busy;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] imem_rdata;
    logic [31:0] pc;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_instr;
    logic        ifid_valid;
    logic        pc_write;
    logic        ifid_write;
    logic        ctrl_sel;
    logic        stall_err;
    logic [31:0] stall_count;
    logic [31:0] flush_count;

    modport slave (
        input  stall, mem_busy, branch_taken, branch_target, imem_rdata,
        output pc, ifid_pc, ifid_instr, ifid_valid, pc_write, ifid_write,
        output ctrl_sel, stall_err, stall_count, flush_count
    );

    modport master (
        output stall, mem_busy, branch_taken, branch_target, imem_rdata,
        input  pc, ifid_pc, ifid_instr, ifid_valid, pc_write, ifid_write,
        input  ctrl_sel, stall_err, stall_count, flush_count
    );
endinterface

// File: rtl/ifid_stall_flush_ctrl.sv
// PC / IF-ID register owner handling load-use stalls, branch flushes, memory-wait freeze and a stall watchdog.
// Define IFID_PERF_CNT_EN to build the stall/flush performance counters; otherwise they read as zero.
module ifid_stall_flush_ctrl #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
    parameter int          MAX_STALL = 4
) (
    input  logic clk,
    input  logic rst,
    ifid_stall_flush_ctrl_if.slave bus
);

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;
    localparam int         SW      = $clog2(MAX_STALL + 1);

    logic [0:0]    r_state;
    logic [31:0]   r_pc;
    logic [31:0]   r_ifid_pc;
    logic [31:0]   r_ifid_instr;
    logic          r_ifid_valid;
    logic          r_pend_flush;
    logic [31:0]   r_pend_target;
    logic [SW-1:0] r_stall_run;
    logic          r_stall_err;

    logic          w_flush;
    logic [31:0]   w_target;
    logic          w_freeze;
    logic          w_stall;
    logic          w_advance;
    logic [SW-1:0] w_stall_next;

    // While frozen a branch is only captured; it takes effect once memory is ready again.
    assign w_flush      = (r_state == ST_RUN) ? bus.branch_taken
                        : (~bus.mem_busy & (bus.branch_taken | r_pend_flush));
    assign w_target     = bus.branch_taken ? bus.branch_target : r_pend_target;
    assign w_freeze     = bus.mem_busy & ~w_flush;
    assign w_stall      = bus.stall & ~bus.mem_busy & ~w_flush;
    assign w_advance    = ~bus.stall & ~bus.mem_busy & ~w_flush;
    assign w_stall_next = (r_stall_run == SW'(MAX_STALL)) ? r_stall_run : r_stall_run + 1'b1;

    assign bus.pc_write   = w_flush | w_advance;
    assign bus.ifid_write = w_flush | w_advance;
    assign bus.ctrl_sel   = (w_freeze | w_advance) & r_ifid_valid;
    assign bus.pc         = r_pc;
    assign bus.ifid_pc    = r_ifid_pc;
    assign bus.ifid_instr = r_ifid_instr;
    assign bus.ifid_valid = r_ifid_valid;
    assign bus.stall_err  = r_stall_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_RUN;
            r_pc          <= RESET_PC;
            r_ifid_pc     <= 32'h0;
            r_ifid_instr  <= NOP_INSTR;
            r_ifid_valid  <= 1'b0;
            r_pend_flush  <= 1'b0;
            r_pend_target <= 32'h0;
        end else if (w_flush) begin
            r_state       <= ST_RUN;
            r_pc          <= w_target;
            r_ifid_pc     <= 32'h0;
            r_ifid_instr  <= NOP_INSTR;
            r_ifid_valid  <= 1'b0;
            r_pend_flush  <= 1'b0;
        end else if (bus.mem_busy) begin
            r_state <= ST_HOLD;
            if (bus.branch_taken) begin
                r_pend_flush  <= 1'b1;
                r_pend_target <= bus.branch_target;
            end
        end else begin
            r_state <= ST_RUN;
            if (!bus.stall) begin
                r_pc         <= r_pc + 32'd4;
                r_ifid_pc    <= r_pc;
                r_ifid_instr <= bus.imem_rdata;
                r_ifid_valid <= 1'b1;
            end
        end
    end

    // A stall seen during a memory freeze neither counts nor clears the run.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_run <= '0;
            r_stall_err <= 1'b0;
        end else if (w_stall) begin
            r_stall_run <= w_stall_next;
            if (w_stall_next == SW'(MAX_STALL)) begin
                r_stall_err <= 1'b1;
            end
        end else if (!bus.stall || w_flush) begin
            r_stall_run <= '0;
        end
    end

`ifdef IFID_PERF_CNT_EN
    logic [31:0] r_stall_count;
    logic [31:0] r_flush_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_count <= 32'h0;
            r_flush_count <= 32'h0;
        end else begin
            if (w_stall) begin
                r_stall_count <= r_stall_count + 32'd1;
            end
            if (w_flush) begin
                r_flush_count <= r_flush_count + 32'd1;
            end
        end
    end

    assign bus.stall_count = r_stall_count;
    assign bus.flush_count = r_flush_count;
`else
    assign bus.stall_count = 32'h0;
    assign bus.flush_count = 32'h0;
`endif

endmodule
